// File: rtl/game_turn_ctrl_if.sv
// Battleship turn sequencer bus: mouse/decoder and board on one side,
// the sequencer on the other.
interface game_turn_ctrl_if #(
    parameter int SHIPS = 4
);
    localparam int HW = $clog2(SHIPS + 1);

    logic          start_btn;
    logic          click;
    logic [5:0]    click_pos;
    logic [1:0]    cell_code;
    logic [1:0]    phase;
    logic [5:0]    cell_addr;
    logic          place;
    logic          turn_guest;
    logic          hit;
    logic          miss;
    logic [HW-1:0] host_hits;
    logic [HW-1:0] guest_hits;
    logic          game_over;
    logic          winner_guest;

    modport master (
        output start_btn, click, click_pos, cell_code,
        input  phase, cell_addr, place, turn_guest, hit, miss,
        input  host_hits, guest_hits, game_over, winner_guest
    );

    modport slave (
        input  start_btn, click, click_pos, cell_code,
        output phase, cell_addr, place, turn_guest, hit, miss,
        output host_hits, guest_hits, game_over, winner_guest
    );
endinterface

// File: rtl/game_turn_ctrl.sv
// Battleship game sequencer: placement, alternating fire turns, hit scoring.
// Optional turn timeout enabled by defining TURN_TIMEOUT_EN.
module game_turn_ctrl #(
    parameter int SHIPS          = 4,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    game_turn_ctrl_if.slave    bus
);
    localparam int HW = $clog2(SHIPS + 1);
    localparam logic [HW-1:0] FULL = HW'(SHIPS);

    typedef enum logic [2:0] {
        IDLE, PL_HOST, CK_HOST, PL_GUEST,
        CK_GUEST, FIRE, CK_FIRE, OVER
    } state_t;

    state_t        state, state_nx;
    logic          settle, settle_nx;
    logic [5:0]    addr, addr_nx;
    logic          turn, turn_nx;
    logic          win, win_nx;
    logic [HW-1:0] placed, placed_nx;
    logic [HW-1:0] hh, hh_nx;
    logic [HW-1:0] gh, gh_nx;
    logic [HW-1:0] cnt, cnt_inc;
    logic          place, hit, miss;
    logic          tmo;

`ifdef TURN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr;

    assign tmo = (state == FIRE) && (tmr == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmr <= '0;
        else if (state != FIRE || state_nx != FIRE || tmo)
            tmr <= '0;
        else
            tmr <= tmr + 1'b1;
    end
`else
    localparam int unused_tmo = TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            settle <= 1'b0;
            addr   <= '0;
            turn   <= 1'b0;
            win    <= 1'b0;
            placed <= '0;
            hh     <= '0;
            gh     <= '0;
        end else begin
            state  <= state_nx;
            settle <= settle_nx;
            addr   <= addr_nx;
            turn   <= turn_nx;
            win    <= win_nx;
            placed <= placed_nx;
            hh     <= hh_nx;
            gh     <= gh_nx;
        end
    end

    // CK_* spend their first cycle waiting for the board read of cell_addr
    always_comb begin
        state_nx  = state;
        settle_nx = 1'b0;
        addr_nx   = addr;
        turn_nx   = turn;
        win_nx    = win;
        placed_nx = placed;
        hh_nx     = hh;
        gh_nx     = gh;
        place     = 1'b0;
        hit       = 1'b0;
        miss      = 1'b0;
        cnt       = turn ? gh : hh;
        cnt_inc   = (cnt == FULL) ? FULL : cnt + 1'b1;
        unique case (state)
            IDLE, OVER: begin
                if (bus.start_btn) begin
                    state_nx  = PL_HOST;
                    turn_nx   = 1'b0;
                    win_nx    = 1'b0;
                    placed_nx = '0;
                    hh_nx     = '0;
                    gh_nx     = '0;
                end
            end
            PL_HOST, PL_GUEST, FIRE: begin
                if (bus.click) begin
                    addr_nx   = bus.click_pos;
                    settle_nx = 1'b1;
                    unique case (state)
                        PL_HOST:  state_nx = CK_HOST;
                        PL_GUEST: state_nx = CK_GUEST;
                        default:  state_nx = CK_FIRE;
                    endcase
                end else if (tmo) begin
                    turn_nx = ~turn;
                end
            end
            CK_HOST, CK_GUEST: begin
                if (!settle) begin
                    state_nx = (state == CK_HOST) ? PL_HOST : PL_GUEST;
                    if (bus.cell_code == 2'b00) begin
                        place = 1'b1;
                        if (placed == FULL - 1'b1) begin
                            placed_nx = '0;
                            state_nx  = (state == CK_HOST) ? PL_GUEST : FIRE;
                        end else begin
                            placed_nx = placed + 1'b1;
                        end
                    end
                end
            end
            CK_FIRE: begin
                if (!settle) begin
                    state_nx = FIRE;
                    unique case (bus.cell_code)
                        2'b01: begin
                            place = 1'b1;
                            hit   = 1'b1;
                            if (turn) gh_nx = cnt_inc;
                            else      hh_nx = cnt_inc;
                            if (cnt_inc == FULL) begin
                                state_nx = OVER;
                                win_nx   = turn;
                            end
                        end
                        2'b00: begin
                            place   = 1'b1;
                            miss    = 1'b1;
                            turn_nx = ~turn;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.phase = 2'b11;
        unique case (state)
            PL_HOST, CK_HOST:   bus.phase = 2'b01;
            PL_GUEST, CK_GUEST: bus.phase = 2'b10;
            FIRE, CK_FIRE:      bus.phase = 2'b00;
            default:            bus.phase = 2'b11;
        endcase
    end

    assign bus.cell_addr    = addr;
    assign bus.place        = place;
    assign bus.hit          = hit;
    assign bus.miss         = miss;
    assign bus.turn_guest   = turn;
    assign bus.host_hits    = hh;
    assign bus.guest_hits   = gh;
    assign bus.game_over    = (state == OVER);
    assign bus.winner_guest = win;
endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench for game_turn_ctrl with a behavioural two-board model.
// Define TURN_TIMEOUT_EN to also exercise the turn timeout.
module tb_game_turn_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ntests = 0;
    int   nfail = 0;
    int   np = 0;
    int   nh = 0;
    int   nm = 0;

    game_turn_ctrl_if #(.SHIPS(4)) bus ();

    game_turn_ctrl #(
        .SHIPS(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // board model: registered read, write on place strobe
    logic [1:0] hb [64];
    logic [1:0] gb [64];
    logic [1:0] cc;
    logic       gsel;
    logic [1:0] rd;
    logic [1:0] wr;

    assign gsel = (bus.phase == 2'b10) ||
                  (bus.phase == 2'b00 && !bus.turn_guest);
    assign rd = gsel ? gb[bus.cell_addr] : hb[bus.cell_addr];
    assign wr = (bus.phase == 2'b00) ?
                ((rd == 2'b01) ? 2'b10 : 2'b11) : 2'b01;
    assign bus.cell_code = cc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                hb[i] <= 2'b00;
                gb[i] <= 2'b00;
            end
            cc <= 2'b00;
        end else begin
            cc <= rd;
            if (bus.place) begin
                if (gsel) gb[bus.cell_addr] <= wr;
                else      hb[bus.cell_addr] <= wr;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.place) np++;
        if (bus.hit)   nh++;
        if (bus.miss)  nm++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_click(input logic [5:0] p);
        bus.click_pos = p;
        bus.click = 1'b1;
        @(negedge clk);
        bus.click = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_start;
        bus.start_btn = 1'b1;
        @(negedge clk);
        bus.start_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_phase"}, 32'(bus.phase), 32'd3);
        chk({tag, "_addr"}, 32'(bus.cell_addr), 32'd0);
        chk({tag, "_pulses"}, {29'd0, bus.place, bus.hit, bus.miss}, 32'd0);
        chk({tag, "_turn"}, 32'(bus.turn_guest), 32'd0);
        chk({tag, "_hh"}, 32'(bus.host_hits), 32'd0);
        chk({tag, "_gh"}, 32'(bus.guest_hits), 32'd0);
        chk({tag, "_over"}, 32'(bus.game_over), 32'd0);
        chk({tag, "_win"}, 32'(bus.winner_guest), 32'd0);
    endtask

    initial begin
        int p0;
        int h0;
        int m0;
        logic t0;
        bus.start_btn = 1'b0;
        bus.click = 1'b0;
        bus.click_pos = '0;
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        rst = 1'b0;
        @(negedge clk);

        do_start();
        chk("start_phase", 32'(bus.phase), 32'd1);
        p0 = np;
        do_click(6'd0);
        do_click(6'd1);
        do_click(6'd2);
        chk("host3_place", 32'(np - p0), 32'd3);
        chk("host3_phase", 32'(bus.phase), 32'd1);
        do_click(6'd0);
        chk("repeat0_noplace", 32'(np - p0), 32'd3);
        do_click(6'd3);
        chk("host4_place", 32'(np - p0), 32'd4);
        chk("host4_phase", 32'(bus.phase), 32'd2);

        do_click(6'd8);
        do_click(6'd9);
        do_click(6'd10);
        do_click(6'd11);
        chk("guest_place", 32'(np - p0), 32'd8);
        chk("fire_phase", 32'(bus.phase), 32'd0);
        chk("fire_turn", 32'(bus.turn_guest), 32'd0);

        m0 = nm;
        bus.click_pos = 6'd0;
        bus.click = 1'b1;
        @(negedge clk);
        bus.click = 1'b0;
        chk("miss_n1", 32'(bus.miss), 32'd0);
        @(negedge clk);
        chk("miss_n2", 32'(bus.miss), 32'd1);
        chk("miss_n2_turn", 32'(bus.turn_guest), 32'd0);
        @(negedge clk);
        chk("miss_n3", 32'(bus.miss), 32'd0);
        chk("miss_n3_turn", 32'(bus.turn_guest), 32'd1);
        chk("miss_count", 32'(nm - m0), 32'd1);
        repeat (2) @(negedge clk);

        do_click(6'd5);
        chk("gmiss_turn", 32'(bus.turn_guest), 32'd0);
        chk("gmiss_count", 32'(nm - m0), 32'd2);

        h0 = nh;
        do_click(6'd8);
        chk("hit1_hh", 32'(bus.host_hits), 32'd1);
        chk("hit1_turn", 32'(bus.turn_guest), 32'd0);
        p0 = np;
        do_click(6'd8);
        chk("code10_place", 32'(np - p0), 32'd0);
        chk("code10_hit", 32'(nh - h0), 32'd1);
        chk("code10_miss", 32'(nm - m0), 32'd2);
        chk("code10_turn", 32'(bus.turn_guest), 32'd0);

        bus.click_pos = 6'd9;
        bus.click = 1'b1;
        @(negedge clk);
        bus.click_pos = 6'd10;
        @(negedge clk);
        bus.click = 1'b0;
        repeat (4) @(negedge clk);
        chk("drop_hits", 32'(nh - h0), 32'd2);
        chk("drop_hh", 32'(bus.host_hits), 32'd2);

        do_click(6'd10);
        chk("hit3_over", 32'(bus.game_over), 32'd0);
        do_click(6'd11);
        chk("win_hits", 32'(nh - h0), 32'd4);
        chk("win_hh", 32'(bus.host_hits), 32'd4);
        chk("win_gh", 32'(bus.guest_hits), 32'd0);
        chk("win_over", 32'(bus.game_over), 32'd1);
        chk("win_guest", 32'(bus.winner_guest), 32'd0);
        chk("win_turn", 32'(bus.turn_guest), 32'd0);
        chk("win_phase", 32'(bus.phase), 32'd3);
        do_click(6'd12);
        chk("over_drop", 32'(bus.phase), 32'd3);

        do_start();
        chk("restart_phase", 32'(bus.phase), 32'd1);
        chk("restart_hh", 32'(bus.host_hits), 32'd0);
        chk("restart_over", 32'(bus.game_over), 32'd0);
        for (int i = 20; i < 24; i++) do_click(6'(i));
        for (int i = 30; i < 34; i++) do_click(6'(i));
        chk("g2_phase", 32'(bus.phase), 32'd0);
        do_click(6'd30);
        do_click(6'd31);
        chk("g2_hh", 32'(bus.host_hits), 32'd2);

`ifdef TURN_TIMEOUT_EN
        t0 = bus.turn_guest;
        h0 = nh;
        m0 = nm;
        repeat (20) @(negedge clk);
        chk("tmo_turn", 32'(bus.turn_guest), 32'(~t0));
        chk("tmo_phase", 32'(bus.phase), 32'd0);
        chk("tmo_pulses", 32'((nh - h0) + (nm - m0)), 32'd0);
`else
        t0 = bus.turn_guest;
        repeat (20) @(negedge clk);
        chk("notmo_turn", 32'(bus.turn_guest), 32'(t0));
`endif

        rst = 1'b1;
        @(negedge clk);
        chk_reset("rst_mid");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_phase", 32'(bus.phase), 32'd3);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/game_turn_ctrl.md
# game_turn_ctrl

Sequencer for the battleship game board: walks the game through host ship placement, guest ship placement and alternating firing turns, driving the board's phase and strobe inputs. It sits between the mouse/cell decoder and the board matrix, reads back the 2-bit cell code of each clicked cell, and counts hits to declare a winner. Host and guest boards are 8x8, addressed {row[2:0], col[2:0]}.

## Interface
- SHIPS, 4: ship cells per player; placement count and winning hit count.
- TIMEOUT_CYCLES, 100_000_000: turn timeout length, used only with TURN_TIMEOUT_EN.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- start_btn  in  1  one-cycle pulse; starts a game from IDLE or OVER.
- click  in  1  one-cycle pulse; mouse click on a valid cell.
- click_pos  in  6  clicked cell {row, col}.
- cell_code  in  2  board code of cell_addr (00 empty, 01 ship, 10 hit, 11 miss), valid one cycle after cell_addr changes.
- phase  out  2  board phase: 01 host placing, 10 guest placing, 00 firing, 11 idle/over.
- cell_addr  out  6  registered cell under evaluation.
- place  out  1  one-cycle strobe: board writes cell_addr.
- turn_guest  out  1  0 host fires, 1 guest fires.
- hit, miss  out  1  one-cycle result pulses.
- host_hits, guest_hits  out  $clog2(SHIPS+1)  hits scored by each player.
- game_over  out  1  level, high in OVER.
- winner_guest  out  1  valid while game_over: 0 host won, 1 guest won.

## Operation
- States: IDLE, PL_HOST, CK_HOST, PL_GUEST, CK_GUEST, FIRE, CK_FIRE, OVER.
- IDLE/OVER: phase=11; start_btn -> clear counters and winner_guest, turn_guest=0, go PL_HOST.
- PL_HOST (phase=01) / PL_GUEST (phase=10): on click latch click_pos into cell_addr, go CK_x.
- CK_x: code 00 -> place pulse, placed count +1; count==SHIPS -> clear count, next phase (PL_HOST->PL_GUEST, PL_GUEST->FIRE); else back to PL_x. Code !=00 -> ignore, back to PL_x, no place.
- FIRE (phase=00): on click latch cell_addr, go CK_FIRE. Target board is opponent's (board selects by turn_guest).
- CK_FIRE: 01 -> place, hit, shooter's counter +1; counter==SHIPS -> OVER, winner_guest=turn_guest; else FIRE, same player fires again. 00 -> place, miss, toggle turn_guest, back to FIRE. 10/11 -> no strobe, back to FIRE, same player.
- Clicks in CK_* states, IDLE, OVER are dropped; start_btn outside IDLE/OVER ignored.
- Hit counters saturate at SHIPS.

## Timing
- Reset: state IDLE, phase=11, cell_addr=0, place=0, hit=0, miss=0, turn_guest=0, counters=0, game_over=0, winner_guest=0.
- click in cycle N -> cell_addr valid N+1 -> cell_code sampled N+2 -> place/hit/miss high in N+2 for one cycle; phase/turn_guest update N+3.
- place, hit, miss never high on consecutive cycles; hit and miss mutually exclusive.
- Reset mid-game aborts immediately to IDLE; board must be reset by the same rst.

## Configuration
- TURN_TIMEOUT_EN defined: cycle counter runs in FIRE, cleared on every state entry; reaching TIMEOUT_CYCLES-1 toggles turn_guest, stays FIRE, no strobes.
- Undefined: no counter, a turn lasts indefinitely.

## Test plan
- Reset mid-FIRE with host_hits=2 -> phase=11, counters 0, all pulses low.
- start_btn, 4 host clicks at empty cells 0,1,2,3 -> 4 place pulses, phase 01->10 after 4th; repeat click on 0 -> no place.
- Guest placement done -> phase=00, turn_guest=0; host clicks guest cell 00 -> miss, turn_guest=1, 3 cycles after click.
- Host hits 4 guest ship cells consecutively -> 4 hit pulses, turn_guest stays 0, game_over=1, winner_guest=0, host_hits=4.
- Click on code 10 cell in FIRE -> no pulses, same player; second click during CK_FIRE dropped.
- TURN_TIMEOUT_EN, TIMEOUT_CYCLES=16: no click for 16 FIRE cycles -> turn_guest toggles once, no hit/miss.
